// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg : shared state encoding, header field positions and lane counts
//              used by the memory loader.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int TGT_BIT = 7;
  localparam int CNT_LSB = 0;
  localparam int CNT_MSB = 6;
  localparam int ILANES  = 2;
  localparam int VLANES  = 4;
  localparam int BYTEW   = 8;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer : little-endian byte-to-word assembly register with lane index.
//               Word_o/Full_o present the completed word in the accept cycle.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_packer #(
  parameter int LANES = 4
) (
  input  logic                 Clk_i,
  input  logic                 Rst_i,
  input  logic                 Clr_i,
  input  logic                 Push_i,
  input  logic [7:0]           Byte_i,
  output logic [8*LANES-1:0]   Word_o,
  output logic                 Full_o
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IW-1:0]        idx_q, idx_d;
  logic [8*LANES-1:0]   data_q;

  // Incoming byte is merged combinationally so the final lane is visible now.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign Word_o[8*l +: 8] = (Push_i && (idx_q == IW'(l))) ? Byte_i
                                                             : data_q[8*l +: 8];
  end

  assign Full_o = Push_i && (idx_q == IW'(LANES - 1));

  always_comb begin
    idx_d = idx_q;
    if (Clr_i) begin
      idx_d = '0;
    end else if (Push_i) begin
      idx_d = Full_o ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      idx_q <= idx_d;
      if (Push_i && !Clr_i) begin
        data_q <= Word_o;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader : framed byte-stream loader for instruction and vector memories;
//              holds the core while a frame is in progress.
//              Optional trailing XOR checksum byte enabled by LOADER_CSUM_EN.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_loader
  import loader_pkg::*;
#(
  parameter int ADRW = 8,
  parameter int IDW  = 16,
  parameter int VDW  = 32,
  parameter int CNTW = 7
) (
  input  logic            Clk_i,
  input  logic            Rst_i,
  input  logic [7:0]      Byte_i,
  input  logic            ByteVld_i,
  output logic            ByteRdy_o,
  output logic            IWEn_o,
  output logic            VWEn_o,
  output logic [ADRW-1:0] WAddr_o,
  output logic [VDW-1:0]  WData_o,
  output logic            Hold_o,
  output logic            Done_o,
  output logic            Err_o
);

  state_e            state_q, state_d;
  logic              tgt_q, tgt_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [ADRW-1:0]   addr_q, addr_d;
  logic [ADRW-1:0]   waddr_q, waddr_d;
  logic [VDW-1:0]    wdata_q, wdata_d;
  logic              iwen_q, iwen_d;
  logic              vwen_q, vwen_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              w_xfer;
  logic              w_hdr_bad;
  logic              w_ipush, w_vpush, w_pclr;
  logic              w_ifull, w_vfull;
  logic [8*ILANES-1:0] w_iword;
  logic [8*VLANES-1:0] w_vword;

  assign ByteRdy_o = (state_q != ST_DONE);
  assign w_xfer    = ByteVld_i & ByteRdy_o;

  // Header bits above the count field must be zero; only exist when CNTW < 7.
  if (CNTW < 7) begin : g_hdr_chk
    assign w_hdr_bad = |Byte_i[6:CNTW];
  end else begin : g_hdr_nochk
    assign w_hdr_bad = 1'b0;
  end

  assign w_pclr  = (state_q == ST_ADDR);
  assign w_ipush = w_xfer && (state_q == ST_DATA) && !tgt_q;
  assign w_vpush = w_xfer && (state_q == ST_DATA) &&  tgt_q;

  byte_packer #(.LANES(ILANES)) u_ipack (
    .Clk_i  (Clk_i),
    .Rst_i  (Rst_i),
    .Clr_i  (w_pclr),
    .Push_i (w_ipush),
    .Byte_i (Byte_i),
    .Word_o (w_iword),
    .Full_o (w_ifull)
  );

  byte_packer #(.LANES(VLANES)) u_vpack (
    .Clk_i  (Clk_i),
    .Rst_i  (Rst_i),
    .Clr_i  (w_pclr),
    .Push_i (w_vpush),
    .Byte_i (Byte_i),
    .Word_o (w_vword),
    .Full_o (w_vfull)
  );

`ifdef LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    iwen_d  = 1'b0;
    vwen_d  = 1'b0;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_hdr_bad) begin
            err_d = 1'b1;
          end else begin
            tgt_d   = Byte_i[TGT_BIT];
            cnt_d   = Byte_i[CNT_LSB +: CNTW];
            hold_d  = 1'b1;
            state_d = ST_ADDR;
`ifdef LOADER_CSUM_EN
            csum_d  = Byte_i;
`endif
          end
        end
      end
      ST_ADDR: begin
        if (w_xfer) begin
          addr_d  = ADRW'(Byte_i);
          state_d = ST_DATA;
`ifdef LOADER_CSUM_EN
          csum_d  = csum_q ^ Byte_i;
`endif
        end
      end
      ST_DATA: begin
`ifdef LOADER_CSUM_EN
        if (w_xfer) begin
          csum_d = csum_q ^ Byte_i;
        end
`endif
        // Strobe is registered, so the next word's first byte is never blocked.
        if (tgt_q ? w_vfull : w_ifull) begin
          iwen_d  = !tgt_q;
          vwen_d  = tgt_q;
          waddr_d = addr_q;
          wdata_d = tgt_q ? VDW'(w_vword) : VDW'(w_iword[IDW-1:0]);
          addr_d  = addr_q + ADRW'(1);
          if (cnt_q == '0) begin
`ifdef LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
      end
`ifdef LOADER_CSUM_EN
      ST_CSUM: begin
        if (w_xfer) begin
          if (Byte_i != csum_q) begin
            err_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q <= ST_IDLE;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      iwen_q  <= 1'b0;
      vwen_q  <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      iwen_q  <= iwen_d;
      vwen_q  <= vwen_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign IWEn_o  = iwen_q;
  assign VWEn_o  = vwen_q;
  assign WAddr_o = waddr_q;
  assign WData_o = wdata_q;
  assign Hold_o  = hold_q;
  assign Done_o  = done_q;
  assign Err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader : scoreboard bench for mem_loader (directed frames).
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        vld;
  logic        rdy;
  logic        iwen, vwen;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        hold, done, err;

  mem_loader u_dut (
    .Clk_i     (clk),
    .Rst_i     (rst),
    .Byte_i    (byte_in),
    .ByteVld_i (vld),
    .ByteRdy_o (rdy),
    .IWEn_o    (iwen),
    .VWEn_o    (vwen),
    .WAddr_o   (waddr),
    .WData_o   (wdata),
    .Hold_o    (hold),
    .Done_o    (done),
    .Err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  a;
    logic [31:0] d;
  } exp_t;
  typedef logic [7:0] bvec_t [16];

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic expect_hold = 1'b0;
  logic prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a write strobe is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (iwen && vwen) chk("both_strobes", 32'd1, 32'd0);
      if (iwen || vwen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'd0, waddr}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_target_vec", {31'd0, vwen}, {31'd0, e.v});
          chk("wr_addr", {24'd0, waddr}, {24'd0, e.a});
          chk("wr_data", wdata, e.d);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_after_write", {31'd0, prev_wr}, 32'd1);
        chk("hold_low_at_done", {31'd0, hold}, 32'd0);
        expect_hold = 1'b0;
      end else if (expect_hold) begin
        chk("hold_in_frame", {31'd0, hold}, 32'd1);
      end
      prev_wr = iwen | vwen;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      vld = 1'b0;
    end
    @(negedge clk);
    vld     = 1'b1;
    byte_in = b;
    t = 0;
    while (!rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) chk("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    vld = 1'b0;
  endtask

  int gaps [8] = '{3, 0, 5, 1, 2, 4, 0, 2};

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] adr,
                            input bvec_t bytes, input int n, input bit stall,
                            input bit bad_csum);
    logic [7:0] cs;
    cs = hdr ^ adr;
    send_byte(hdr, 0);
    expect_hold = 1'b1;
    send_byte(adr, stall ? gaps[7] : 0);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i], stall ? gaps[i % 8] : 0);
      cs = cs ^ bytes[i];
    end
`ifdef LOADER_CSUM_EN
    send_byte(bad_csum ? ~cs : cs, 0);
`else
    if (bad_csum) cs = ~cs;
`endif
    idle_bus();
  endtask

  task automatic wait_done(input string name);
    int start;
    int t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk({name, "_done"}, {31'd0, (done_cnt > start)}, 32'd1);
    @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  function automatic exp_t mk(input logic v, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.v = v; e.a = a; e.d = d;
    return e;
  endfunction

  bvec_t b;

  initial begin
    rst = 1'b1;
    vld = 1'b0;
    byte_in = 8'h00;
    b = '{default: 8'h00};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",  {31'd0, rdy},  32'd1);
    chk("rst_iwen", {31'd0, iwen}, 32'd0);
    chk("rst_vwen", {31'd0, vwen}, 32'd0);
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    chk("rst_addr", {24'd0, waddr}, 32'd0);
    chk("rst_data", wdata, 32'd0);
    rst = 1'b0;

    // Instruction load, back-to-back
    b[0] = 8'h34; b[1] = 8'h12; b[2] = 8'h78; b[3] = 8'h56;
    exp_q.push_back(mk(1'b0, 8'h10, 32'h0000_1234));
    exp_q.push_back(mk(1'b0, 8'h11, 32'h0000_5678));
    send_frame(8'h01, 8'h10, b, 4, 1'b0, 1'b0);
    wait_done("iload");

    // Vector load
    b[0] = 8'hDD; b[1] = 8'hCC; b[2] = 8'hBB; b[3] = 8'hAA;
    exp_q.push_back(mk(1'b1, 8'h05, 32'hAABB_CCDD));
    send_frame(8'h80, 8'h05, b, 4, 1'b0, 1'b0);
    wait_done("vload");

    // Address wrap 0xFF -> 0x00
    for (int i = 0; i < 8; i++) b[i] = 8'(i + 1);
    exp_q.push_back(mk(1'b1, 8'hFF, 32'h0403_0201));
    exp_q.push_back(mk(1'b1, 8'h00, 32'h0807_0605));
    send_frame(8'h81, 8'hFF, b, 8, 1'b0, 1'b0);
    wait_done("wrap");
    chk("wrap_err", {31'd0, err}, 32'd0);

    // Stalled stream, same instruction frame
    b[0] = 8'h34; b[1] = 8'h12; b[2] = 8'h78; b[3] = 8'h56;
    exp_q.push_back(mk(1'b0, 8'h10, 32'h0000_1234));
    exp_q.push_back(mk(1'b0, 8'h11, 32'h0000_5678));
    send_frame(8'h01, 8'h10, b, 4, 1'b1, 1'b0);
    wait_done("stall");

    // Reset after third payload byte of a vector frame
    send_byte(8'h80, 0);
    send_byte(8'h05, 0);
    send_byte(8'hDD, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hBB, 0);
    #2;
    vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_hold", {31'd0, hold}, 32'd0);
    chk("midrst_rdy",  {31'd0, rdy},  32'd1);
    chk("midrst_vwen", {31'd0, vwen}, 32'd0);
    chk("midrst_err",  {31'd0, err},  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
    exp_q.push_back(mk(1'b1, 8'h20, 32'h4433_2211));
    send_frame(8'h80, 8'h20, b, 4, 1'b0, 1'b0);
    wait_done("postrst");

`ifdef LOADER_CSUM_EN
    b[0] = 8'h34; b[1] = 8'h12; b[2] = 8'h78; b[3] = 8'h56;
    exp_q.push_back(mk(1'b0, 8'h10, 32'h0000_1234));
    exp_q.push_back(mk(1'b0, 8'h11, 32'h0000_5678));
    send_frame(8'h01, 8'h10, b, 4, 1'b0, 1'b0);
    wait_done("csum_ok");
    chk("csum_ok_err", {31'd0, err}, 32'd0);
    exp_q.push_back(mk(1'b0, 8'h10, 32'h0000_1234));
    exp_q.push_back(mk(1'b0, 8'h11, 32'h0000_5678));
    send_frame(8'h01, 8'h10, b, 4, 1'b0, 1'b1);
    wait_done("csum_bad");
    chk("csum_bad_err", {31'd0, err}, 32'd1);
    repeat (5) @(negedge clk);
    chk("csum_err_sticky", {31'd0, err}, 32'd1);
`endif

    chk("done_total", done_cnt,
`ifdef LOADER_CSUM_EN
        32'd7
`else
        32'd5
`endif
    );
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Host-side writer that fills the instruction memory and the vector data memory before the core runs.
- Accepts a framed byte stream over a valid/ready handshake.
- Assembles the bytes into 16-bit instruction words or 32-bit vector words and drives single-cycle memory write strobes.
- Holds the core in reset (Hold_o) while a frame is in progress.

Parameters:
- ADRW, 8, width of the word address on the memory write port
- IDW, 16, instruction word width (2 bytes)
- VDW, 32, vector data word width (4 bytes)
- CNTW, 7, width of the header word-count field

Ports:
- Clk_i  in  1  clock
- Rst_i  in  1  reset, asynchronous, active-high
- Byte_i  in  8  stream byte
- ByteVld_i  in  1  Byte_i valid
- ByteRdy_o  out  1  loader can accept a byte
- IWEn_o  out  1  instruction memory write strobe
- VWEn_o  out  1  vector memory write strobe
- WAddr_o  out  ADRW  word write address
- WData_o  out  VDW  write data; instruction writes use bits [IDW-1:0], upper bits zero
- Hold_o  out  1  core hold; high from header accept until Done_o
- Done_o  out  1  one-cycle pulse at frame completion
- Err_o  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, Clk_i. Reset Rst_i is asynchronous, active-high.
- Reset values: all outputs 0, except ByteRdy_o=1. State=IDLE.
- A byte transfers on a rising edge with ByteVld_i & ByteRdy_o.
- Frame format: HDR, ADDR, payload, then CSUM only under the optional feature.
  - HDR: bit7 = target (0 = instruction memory, 1 = vector memory); bits[CNTW-1:0] = word count minus 1, so 1..128 words.
  - ADDR: start word address, zero-extended to ADRW.
  - Payload: count × (2 or 4) bytes per word, little-endian, first byte = bits[7:0].
- States:
  - IDLE: accept HDR, latch target and count, set Hold_o=1, go to ADDR.
  - ADDR: accept address into the address register, clear the byte index, go to DATA.
  - DATA: shift each byte into the assembly register at lane index.
    - On the last lane byte, the next cycle asserts IWEn_o or VWEn_o for exactly one cycle, with WAddr_o = current address and WData_o = the assembled word.
    - The address then increments modulo 2^ADRW, so addresses wrap from 255 to 0 with no error.
    - The word counter decrements.
    - After the last word go to DONE (or CSUM when the feature is enabled).
  - DONE: ByteRdy_o=0 for one cycle, Done_o=1, Hold_o falls to 0 on the same edge that Done_o rises, return to IDLE.
- Write latency: 1 cycle after the final byte of a word.
- ByteRdy_o stays high in IDLE, ADDR and DATA. Back-to-back bytes are sustained at 1 byte/cycle, because a write strobe never blocks acceptance of the next word's first byte.
- Gaps in ByteVld_i: state is held, and no strobe fires without a completed word.
- Hold_o stays high across idle gaps within a frame.
- Err_o: set when HDR arrives with bits[6:CNTW] nonzero (only possible if CNTW<7). The frame is dropped and the state stays IDLE.
- Err_o clears only on reset.
- Reset mid-frame: the state returns to IDLE asynchronously. Partial word is discarded, no strobe, Hold_o=0. Memory words already written remain.
- IWEn_o and VWEn_o are never high together.

Optional Feature:
- Macro: LOADER_CSUM_EN.
- When defined:
  - A CSUM byte follows the payload.
  - Running 8-bit XOR over HDR, ADDR and all payload bytes.
  - State CSUM accepts one byte. On mismatch Err_o=1 (sticky). DONE and Done_o occur regardless.
  - Writes are not rolled back.
- When undefined:
  - There is no CSUM state; DATA goes directly to DONE.
  - The XOR logic is absent.

Decomposition:
- Shared package loader_pkg holds:
  - state encoding: IDLE, ADDR, DATA, CSUM, DONE
  - header bit positions: TGT_BIT=7, count field LSB/MSB
  - lane counts: ILANES=2, VLANES=4
- One natural sub-module, byte_packer: shift-in assembly register with lane index and a "word complete" output, parameterised by lane count.

Test Plan:
1. Instruction load: HDR 0x01, ADDR 0x10, bytes 34 12 78 56 back-to-back. Required response:
   - IWEn_o pulses at addr 0x10 with data 0x1234, then at 0x11 with 0x5678.
   - Done_o one cycle after the last write.
   - Hold_o high from HDR accept until Done_o.
2. Vector load: HDR 0x80, ADDR 0x05, bytes DD CC BB AA. Required response: a single VWEn_o with WAddr_o=0x05, WData_o=0xAABBCCDD, and IWEn_o=0 throughout.
3. Address wrap: HDR 0x81, ADDR 0xFF, 8 bytes. Required response: writes at 0xFF then 0x00, and Err_o=0.
4. Stalled stream: random ByteVld_i gaps of 0–5 cycles during test 1. Required response: identical writes, no extra strobes, and Hold_o held high through the gaps.
5. Reset mid-frame: assert Rst_i after the 3rd payload byte of test 2. Required response:
   - No VWEn_o.
   - Outputs return to reset values immediately.
   - A following frame loads correctly.
6. LOADER_CSUM_EN: test 1 with a correct CSUM gives Err_o=0. The same frame with a corrupted CSUM gives Err_o=1 that stays set, and Done_o still pulses.
